// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB completer: register map, STATUS layout, FSM states.
package uart_apb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CTRL_W = 2;

  // Register offsets as seen on PADDR[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  // STATUS bit positions
  localparam int unsigned ST_TX_VALID = 0;
  localparam int unsigned ST_RX_EMPTY = 1;
  localparam int unsigned ST_OVERRUN  = 2;
  localparam int unsigned ST_CNT_LSB  = 4;
  localparam int unsigned ST_CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WWAIT  = 2'd2,
    RWAIT  = 2'd3
  } completer_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO; a push on a full FIFO is accepted only when a pop frees a slot that cycle.
module uart_rx_fifo
  import uart_apb_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        i_rst,
  input  logic                        i_push,
  input  logic [BYTE_W-1:0]           i_din,
  input  logic                        i_pop,
  output logic [BYTE_W-1:0]           o_dout,
  output logic [$clog2(RX_DEPTH):0]   o_count,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int unsigned PTR_W = $clog2(RX_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BYTE_W-1:0] r_mem [RX_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_count   = r_count;
  assign o_full    = (r_count == CNT_W'(RX_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (!i_rst && w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/apb_uart_completer.sv
// APB completer for the UART: CTRL/STATUS/TXDATA/RXDATA registers with wait states on
// a busy TX holding register and on an empty RX FIFO (bounded by a read timeout).
module apb_uart_completer
  import uart_apb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned RX_DEPTH   = 4,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  input  logic              rx_valid_i
);

  localparam int unsigned WCNT_W  = $clog2(RD_TIMEOUT + 1);
  localparam int unsigned RXCNT_W = $clog2(RX_DEPTH) + 1;

  completer_state_e    r_state;
  completer_state_e    w_state_nxt;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [BYTE_W-1:0]   r_tx_data;
  logic                r_tx_valid;
  logic                r_overrun;
  logic [WCNT_W-1:0]   r_wait_cnt;

  logic [1:0]          w_reg;
  logic                w_access;
  logic                w_ready;
  logic                w_err;
  logic [DATA_W-1:0]   w_rdata;
  logic [DATA_W-1:0]   w_status;
  logic                w_ctrl_we;
  logic                w_tx_load;
  logic                w_pop;
  logic                w_status_rd;
  logic                w_cnt_clr;
  logic                w_push;
  logic                w_ov_set;
  logic [BYTE_W-1:0]   w_rx_dout;
  logic [RXCNT_W-1:0]  w_rx_count;
  logic                w_rx_full;
  logic                w_rx_empty;
  logic                w_unused;

  assign w_reg    = PADDR[3:2];
  assign w_access = PSEL & PENABLE;
  assign w_push   = rx_valid_i & r_ctrl[1];
  assign w_ov_set = w_push & w_rx_full & ~w_pop;
  assign w_unused = ^{PWDATA[DATA_W-1:BYTE_W], PADDR};

  assign ctrl_o     = r_ctrl;
  assign tx_data_o  = r_tx_data;
  assign tx_valid_o = r_tx_valid;

  // Response is suppressed while reset is held so an aborted access never completes
  assign PREADY  = w_ready & ~PRESET;
  assign PSLVERR = w_err & ~PRESET;
  assign PRDATA  = PRESET ? '0 : w_rdata;

  always_comb begin
    w_status              = '0;
    w_status[ST_TX_VALID] = r_tx_valid;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_OVERRUN]  = r_overrun;
    w_status[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(w_rx_count);
  end

  uart_rx_fifo #(
    .RX_DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (PCLK),
    .i_rst   (PRESET),
    .i_push  (w_push),
    .i_din   (rx_data_i),
    .i_pop   (w_pop),
    .o_dout  (w_rx_dout),
    .o_count (w_rx_count),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and access response; IDLE also serves an access phase seen without setup
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_err       = 1'b0;
    w_rdata     = '0;
    w_ctrl_we   = 1'b0;
    w_tx_load   = 1'b0;
    w_pop       = 1'b0;
    w_status_rd = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      IDLE, ACCESS: begin
        if (w_access) begin
          w_state_nxt = IDLE;
          case (w_reg)
            REG_CTRL: begin
              w_ready = 1'b1;
              if (PWRITE) w_ctrl_we = 1'b1;
              else        w_rdata   = DATA_W'(r_ctrl);
            end
            REG_STATUS: begin
              w_ready = 1'b1;
              if (PWRITE) begin
                w_err = 1'b1;
              end else begin
                w_rdata     = w_status;
                w_status_rd = 1'b1;
              end
            end
            REG_TXDATA: begin
              if (!PWRITE) begin
                w_ready = 1'b1;
                w_err   = 1'b1;
              end else if (!r_tx_valid) begin
                w_ready   = 1'b1;
                w_tx_load = 1'b1;
              end else begin
                w_state_nxt = WWAIT;
              end
            end
            default: begin
              if (PWRITE) begin
                w_ready = 1'b1;
                w_err   = 1'b1;
              end else if (!w_rx_empty) begin
                w_ready = 1'b1;
                w_rdata = DATA_W'(w_rx_dout);
                w_pop   = 1'b1;
              end else begin
                w_state_nxt = RWAIT;
                w_cnt_clr   = 1'b1;
              end
            end
          endcase
        end else if (PSEL) begin
          w_state_nxt = ACCESS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WWAIT: begin
        if (!w_access) begin
          w_state_nxt = IDLE;
        end else if (!r_tx_valid) begin
          w_ready     = 1'b1;
          w_tx_load   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        if (!w_access) begin
          w_state_nxt = IDLE;
        end else if (!w_rx_empty) begin
          w_ready     = 1'b1;
          w_rdata     = DATA_W'(w_rx_dout);
          w_pop       = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_wait_cnt == WCNT_W'(RD_TIMEOUT - 1)) begin
          w_ready     = 1'b1;
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // Register file, TX holding register, overrun flag and read-wait counter
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_ctrl     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      if (w_ctrl_we) r_ctrl <= PWDATA[CTRL_W-1:0];
      if (w_tx_load) r_tx_data <= PWDATA[BYTE_W-1:0];
      if (w_tx_load)                     r_tx_valid <= 1'b1;
      else if (w_ctrl_we && !PWDATA[0])  r_tx_valid <= 1'b0;
      else if (r_tx_valid && tx_ready_i) r_tx_valid <= 1'b0;
      r_overrun <= w_ov_set | (r_overrun & ~w_status_rd);
      if (w_cnt_clr)             r_wait_cnt <= '0;
      else if (r_state == RWAIT) r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
    end
  end

endmodule
